// File: rtl/slm_vga_pkg.sv
// Shared types and constants for the SDRAM-to-VGA line reader.
// Holds the line-reader state enum, default frame geometry and the SDRAM
// word address width, plus the line base address helper.
package slm_vga_pkg;

    localparam int unsigned DefaultLinePixels = 1024;
    localparam int unsigned DefaultNumLines   = 768;
    localparam int unsigned AddrWidth         = 25;
    localparam int unsigned LineIdWidth       = 13;

    typedef logic [AddrWidth-1:0] addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Word address of the first word of a line; wraps in AddrWidth bits.
    function automatic addr_t line_base_addr(input addr_t                  frame_base,
                                             input logic [LineIdWidth-1:0] line_id,
                                             input int unsigned            words_per_line);
        return frame_base + addr_t'(line_id) * addr_t'(words_per_line);
    endfunction

endpackage

// File: rtl/line_word_fifo.sv
// Small show-ahead word FIFO that buffers SDRAM read returns for the line
// reader. rdata always presents the oldest entry while count is non-zero.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module line_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_push = push && (count_q != CntW'(DEPTH));
        do_pop  = pop && (count_q != '0);
    end

    // Storage array, cleared on reset so nothing stale is ever presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Read/write pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/sdram_vga_line_reader.sv
// Fetches one video line of 8-bit pixels from SDRAM (16-bit Avalon reads)
// and streams it byte by byte, low byte first, into a pixel FIFO.
// Reads in flight plus buffered words are capped at MAX_PENDING so every
// returned beat always has room in the local word buffer.
// Out-of-range line IDs produce a line of zero pixels without SDRAM traffic.
// Optional feature: define SDRAM_VGA_LINE_READER_CHECKSUM_EN to enable the
// per-line byte checksum on oLINE_SUM; otherwise oLINE_SUM is tied to zero.
module sdram_vga_line_reader
    import slm_vga_pkg::*;
#(
    parameter int unsigned          LINE_PIXELS = DefaultLinePixels,
    parameter int unsigned          NUM_LINES   = DefaultNumLines,
    parameter logic [AddrWidth-1:0] FRAME_BASE  = 25'h0,
    parameter int unsigned          MAX_PENDING = 4
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   iLOAD_REQ,
    input  logic [LineIdWidth-1:0] iLINE_ID,
    output logic                   oRD_EN,
    output logic [AddrWidth-1:0]   oRD_ADDR,
    input  logic                   iWAIT_REQUEST,
    input  logic [15:0]            iRD_DATA,
    input  logic                   iRD_DATAVALID,
    output logic [7:0]             oWDATA,
    output logic                   oWEN,
    input  logic                   iWFULL,
    output logic                   oBUSY,
    output logic                   oDONE,
    output logic                   oMISSED,
    output logic [15:0]            oLINE_SUM
);

    localparam int unsigned Words    = LINE_PIXELS / 2;
    localparam int unsigned WordCntW = $clog2(Words + 1);
    localparam int unsigned PixCntW  = $clog2(LINE_PIXELS + 1);
    localparam int unsigned PendW    = $clog2(MAX_PENDING + 1);
    localparam int unsigned PendSumW = PendW + 1;

    state_e               state_q;
    logic                 oob_q;
    addr_t                rd_addr_q;
    logic [WordCntW-1:0]  issued_q;
    logic [PendW-1:0]     outstanding_q;
    logic [PixCntW-1:0]   pix_cnt_q;
    logic                 hi_byte_q;
    logic                 done_q;
    logic                 missed_q;

    logic [PendW-1:0]     fifo_count;
    logic                 fifo_empty;
    logic [15:0]          fifo_rdata;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic [PendSumW-1:0]  pending;
    logic                 active;
    logic                 rd_en;
    logic                 rd_accept;
    logic                 last_read;
    logic                 beat;
    logic                 wen;
    logic                 last_pix;
    logic                 line_oob;
    logic [7:0]           wdata;

    line_word_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (16)
    ) u_word_fifo (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .push  (fifo_push),
        .wdata (iRD_DATA),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Read issue, return acceptance and pixel unpacking decisions.
    always_comb begin
        active    = (state_q == StIssue) || (state_q == StDrain);
        pending   = {1'b0, outstanding_q} + {1'b0, fifo_count};
        rd_en     = (state_q == StIssue) && !oob_q &&
                    (issued_q < WordCntW'(Words)) &&
                    (pending < PendSumW'(MAX_PENDING));
        rd_accept = rd_en && !iWAIT_REQUEST;
        last_read = rd_accept && (issued_q == WordCntW'(Words - 1));
        // Beats with nothing outstanding are strays (e.g. after reset) and are dropped.
        beat      = iRD_DATAVALID && (state_q != StIdle) && (outstanding_q != '0);
        fifo_push = beat;
        wen       = active && (pix_cnt_q < PixCntW'(LINE_PIXELS)) &&
                    (oob_q || !fifo_empty) && !iWFULL;
        // A word leaves the buffer once its high byte has been written.
        fifo_pop  = wen && hi_byte_q && !oob_q;
        last_pix  = wen && (pix_cnt_q == PixCntW'(LINE_PIXELS - 1));
        wdata     = 8'h00;
        if (wen && !oob_q) begin
            wdata = hi_byte_q ? fifo_rdata[15:8] : fifo_rdata[7:0];
        end
        line_oob  = (32'(iLINE_ID) >= NUM_LINES);
    end

    // Line FSM with its address, read, pixel and in-flight counters.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q       <= StIdle;
            oob_q         <= 1'b0;
            rd_addr_q     <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            pix_cnt_q     <= '0;
            hi_byte_q     <= 1'b0;
            done_q        <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            missed_q <= iLOAD_REQ && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (iLOAD_REQ) begin
                        state_q   <= StIssue;
                        oob_q     <= line_oob;
                        rd_addr_q <= line_base_addr(FRAME_BASE, iLINE_ID, Words);
                        issued_q  <= '0;
                        pix_cnt_q <= '0;
                        hi_byte_q <= 1'b0;
                    end
                end
                StIssue: begin
                    if (oob_q || last_read) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_pix) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (rd_accept) begin
                rd_addr_q <= rd_addr_q + addr_t'(1);
                issued_q  <= issued_q + WordCntW'(1);
            end
            if (wen) begin
                pix_cnt_q <= pix_cnt_q + PixCntW'(1);
                hi_byte_q <= !hi_byte_q;
            end
            if (rd_accept && !beat) begin
                outstanding_q <= outstanding_q + PendW'(1);
            end else if (!rd_accept && beat) begin
                outstanding_q <= outstanding_q - PendW'(1);
            end
        end
    end

`ifdef SDRAM_VGA_LINE_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running byte sum of the pixels written, restarted on each accepted request.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sum_q <= '0;
        end else if ((state_q == StIdle) && iLOAD_REQ) begin
            sum_q <= '0;
        end else if (wen) begin
            sum_q <= sum_q + {8'h00, wdata};
        end
    end

    assign oLINE_SUM = sum_q;
`else
    assign oLINE_SUM = 16'h0;
`endif

    assign oRD_EN   = rd_en;
    assign oRD_ADDR = rd_addr_q;
    assign oWEN     = wen;
    assign oWDATA   = wdata;
    assign oBUSY    = (state_q != StIdle);
    assign oDONE    = done_q;
    assign oMISSED  = missed_q;

endmodule

// File: tb/tb_sdram_vga_line_reader.sv
// Directed bench for sdram_vga_line_reader with default parameters
// (1024 pixels/line, 768 lines, base 0, 4 pending). A simple Avalon slave
// returns word {addr[7:0]^8'hA5, addr[7:0]} five cycles after acceptance.
module tb_sdram_vga_line_reader;

    localparam int RetLat = 5;

    logic        clk = 1'b0;
    logic        iRST_N;
    logic        iLOAD_REQ;
    logic [12:0] iLINE_ID;
    logic        oRD_EN;
    logic [24:0] oRD_ADDR;
    logic        iWAIT_REQUEST;
    logic [15:0] iRD_DATA;
    logic        iRD_DATAVALID;
    logic [7:0]  oWDATA;
    logic        oWEN;
    logic        iWFULL;
    logic        oBUSY;
    logic        oDONE;
    logic        oMISSED;
    logic [15:0] oLINE_SUM;

    always #5 clk = ~clk;

    sdram_vga_line_reader dut (
        .iCLK          (clk),
        .iRST_N        (iRST_N),
        .iLOAD_REQ     (iLOAD_REQ),
        .iLINE_ID      (iLINE_ID),
        .oRD_EN        (oRD_EN),
        .oRD_ADDR      (oRD_ADDR),
        .iWAIT_REQUEST (iWAIT_REQUEST),
        .iRD_DATA      (iRD_DATA),
        .iRD_DATAVALID (iRD_DATAVALID),
        .oWDATA        (oWDATA),
        .oWEN          (oWEN),
        .iWFULL        (iWFULL),
        .oBUSY         (oBUSY),
        .oDONE         (oDONE),
        .oMISSED       (oMISSED),
        .oLINE_SUM     (oLINE_SUM)
    );

    function automatic logic [15:0] word_of(input logic [24:0] a);
        return {a[7:0] ^ 8'hA5, a[7:0]};
    endfunction

    // ---------------- slave model ----------------
    bit          stall_en;
    bit          full_force;
    int          cyc;
    logic [24:0] ret_addr_q[$];
    int          ret_due_q[$];

    initial begin
        iWAIT_REQUEST = 1'b0;
        iRD_DATAVALID = 1'b0;
        iRD_DATA      = 16'h0;
        iWFULL        = 1'b0;
        cyc           = 0;
        forever begin
            @(negedge clk);
            if (iRST_N && oRD_EN && !iWAIT_REQUEST) begin
                ret_addr_q.push_back(oRD_ADDR);
                ret_due_q.push_back(cyc + RetLat);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
                iRD_DATAVALID = 1'b1;
                iRD_DATA      = word_of(ret_addr_q.pop_front());
                void'(ret_due_q.pop_front());
            end else begin
                iRD_DATAVALID = 1'b0;
                iRD_DATA      = 16'hDEAD;
            end
            iWAIT_REQUEST = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            iWFULL        = full_force;
        end
    end

    // ---------------- monitor / reference model ----------------
    int          line_rd, line_wen, done_cnt, missed_cnt, idle_beats;
    int          data_err, addr_err, stab_viol, full_viol, pend_viol;
    logic [24:0] exp_base, first_addr, prev_addr;
    logic        exp_oob, prev_stall;
    logic [15:0] exp_sum, sum_at_done, mon_w;
    logic [7:0]  mon_eb;

    always @(negedge clk) begin
        if (!iRST_N) begin
            line_rd = 0; line_wen = 0; done_cnt = 0; missed_cnt = 0; idle_beats = 0;
            data_err = 0; addr_err = 0; stab_viol = 0; full_viol = 0; pend_viol = 0;
            exp_base = '0; first_addr = '0; prev_addr = '0; exp_oob = 1'b0;
            prev_stall = 1'b0; exp_sum = '0; sum_at_done = '0;
        end else begin
            if (iLOAD_REQ && !oBUSY) begin
                exp_base = 25'(iLINE_ID) * 25'd512;
                exp_oob  = (iLINE_ID >= 13'd768);
                line_rd = 0; line_wen = 0; done_cnt = 0; missed_cnt = 0; idle_beats = 0;
                data_err = 0; addr_err = 0; stab_viol = 0; full_viol = 0; pend_viol = 0;
                first_addr = '0; prev_stall = 1'b0; exp_sum = '0; sum_at_done = '0;
            end
            if (iRD_DATAVALID && !oBUSY) idle_beats++;
            if (prev_stall && (!oRD_EN || oRD_ADDR !== prev_addr)) stab_viol++;
            if (oRD_EN) begin
                if (oRD_ADDR !== exp_base + 25'(line_rd)) addr_err++;
                if ((line_rd - line_wen / 2) >= 4) pend_viol++;
                if (!iWAIT_REQUEST) begin
                    if (line_rd == 0) first_addr = oRD_ADDR;
                    line_rd++;
                end
            end
            prev_stall = oRD_EN && iWAIT_REQUEST;
            prev_addr  = oRD_ADDR;
            if (oWEN) begin
                if (iWFULL) full_viol++;
                mon_w  = word_of(exp_base + 25'(line_wen / 2));
                mon_eb = exp_oob ? 8'h00 : ((line_wen % 2 == 1) ? mon_w[15:8] : mon_w[7:0]);
                if (oWDATA !== mon_eb) data_err++;
                exp_sum = exp_sum + 16'(mon_eb);
                line_wen++;
            end
            if (oDONE) begin
                done_cnt++;
                sum_at_done = oLINE_SUM;
            end
            if (oMISSED) missed_cnt++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_line_sum();
`ifdef SDRAM_VGA_LINE_READER_CHECKSUM_EN
        return exp_sum;
`else
        return 16'h0;
`endif
    endfunction

    task automatic start_line(input logic [12:0] id, input logic exp_rd_en, input string tag);
        @(posedge clk); #1;
        iLOAD_REQ = 1'b1;
        iLINE_ID  = id;
        @(posedge clk); #1;
        iLOAD_REQ = 1'b0;
        @(negedge clk);
        check({tag, "_first_rd_en"}, 64'(oRD_EN), 64'(exp_rd_en));
        check({tag, "_busy"}, 64'(oBUSY), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (4) @(negedge clk);
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle_after"}, 64'(oBUSY), 64'd0);
    endtask

    task automatic wait_reads(input int n, input string tag);
        int k = 0;
        while (line_rd < n && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reads_reached"}, 64'(line_rd >= n), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int k;
        iRST_N     = 1'b0;
        iLOAD_REQ  = 1'b0;
        iLINE_ID   = '0;
        stall_en   = 1'b0;
        full_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({oRD_EN, oWEN, oBUSY, oDONE, oMISSED, oWDATA, oRD_ADDR, oLINE_SUM}), 64'd0);
        @(posedge clk); #1;
        iRST_N = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal line 3 with a rejected second request during ISSUE.
        start_line(13'd3, 1'b1, "nom");
        repeat (5) @(posedge clk);
        #1;
        iLOAD_REQ = 1'b1;
        iLINE_ID  = 13'd100;
        @(posedge clk); #1;
        iLOAD_REQ = 1'b0;
        wait_done("nom");
        check("nom_first_addr", 64'(first_addr), 64'd1536);
        check("nom_reads", 64'(line_rd), 64'd512);
        check("nom_writes", 64'(line_wen), 64'd1024);
        check("nom_data", 64'(data_err), 64'd0);
        check("nom_addr_seq", 64'(addr_err), 64'd0);
        check("nom_missed", 64'(missed_cnt), 64'd1);
        check("nom_sum", 64'(sum_at_done), 64'(exp_line_sum()));

        // Random read backpressure on line 5.
        stall_en = 1'b1;
        start_line(13'd5, 1'b1, "stall");
        wait_done("stall");
        stall_en = 1'b0;
        check("stall_addr_stable", 64'(stab_viol), 64'd0);
        check("stall_reads", 64'(line_rd), 64'd512);
        check("stall_addr_seq", 64'(addr_err), 64'd0);
        check("stall_first_addr", 64'(first_addr), 64'd2560);
        check("stall_writes", 64'(line_wen), 64'd1024);
        check("stall_data", 64'(data_err), 64'd0);

        // Pixel FIFO full for 100 cycles mid-line on line 7.
        start_line(13'd7, 1'b1, "full");
        k = 0;
        while (line_wen < 300 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        full_force = 1'b1;
        @(negedge clk);
        w0 = line_wen;
        repeat (100) @(negedge clk);
        check("full_no_writes", 64'(line_wen), 64'(w0));
        full_force = 1'b0;
        wait_done("full");
        check("full_wen_while_full", 64'(full_viol), 64'd0);
        check("full_pending_cap", 64'(pend_viol), 64'd0);
        check("full_writes", 64'(line_wen), 64'd1024);
        check("full_data", 64'(data_err), 64'd0);

        // Out-of-range line 800.
        start_line(13'd800, 1'b0, "oob");
        wait_done("oob");
        check("oob_reads", 64'(line_rd), 64'd0);
        check("oob_writes", 64'(line_wen), 64'd1024);
        check("oob_zero_data", 64'(data_err), 64'd0);
        check("oob_sum", 64'(sum_at_done), 64'd0);

        // Reset mid-line on line 9, then stray returns while idle.
        start_line(13'd9, 1'b1, "rst");
        wait_reads(100, "rst");
        @(posedge clk); #1;
        iRST_N = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({oRD_EN, oWEN, oBUSY, oDONE, oMISSED, oWDATA, oRD_ADDR, oLINE_SUM}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        iRST_N = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_stray_beats_seen", 64'(idle_beats > 0), 64'd1);
        check("rst_no_wen", 64'(line_wen), 64'd0);
        check("rst_no_reads", 64'(line_rd), 64'd0);
        check("rst_idle", 64'(oBUSY), 64'd0);

        start_line(13'd11, 1'b1, "post");
        wait_done("post");
        check("post_first_addr", 64'(first_addr), 64'd5632);
        check("post_reads", 64'(line_rd), 64'd512);
        check("post_writes", 64'(line_wen), 64'd1024);
        check("post_data", 64'(data_err), 64'd0);
        check("post_sum", 64'(sum_at_done), 64'(exp_line_sum()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_vga_line_reader.md
SDRAM_VGA_LINE_READER -- requirements
Module: sdram_vga_line_reader

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 1024, meaning 8-bit pixels per line; must be even.
REQ-002 SHALL have parameter NUM_LINES, default 768, meaning valid line IDs 0..NUM_LINES-1.
REQ-003 SHALL have parameter FRAME_BASE, default 25'h0, meaning the SDRAM word address of line 0.
REQ-004 SHALL have parameter MAX_PENDING, default 4, meaning the maximum number of words in flight plus buffered.
REQ-005 iCLK  in  1  sole clock.
REQ-006 iRST_N  in  1  asynchronous active-low reset.
REQ-007 iLOAD_REQ  in  1  one-cycle pulse, synchronous to iCLK, requesting a line fetch.
REQ-008 iLINE_ID  in  13  line to fetch; sampled when iLOAD_REQ is accepted.
REQ-009 oRD_EN, oRD_ADDR  out  1, 25  Avalon read request and word address.
REQ-010 iWAIT_REQUEST  in  1  when high, the slave stalls the current read request.
REQ-011 iRD_DATA, iRD_DATAVALID  in  16, 1  read return data and its valid strobe.
REQ-012 oWDATA, oWEN  out  8, 1  FIFO write data and write enable.
REQ-013 iWFULL  in  1  FIFO full.
REQ-014 oBUSY  out  1  high while a line is in progress.
REQ-015 oDONE  out  1  one-cycle pulse after the last pixel is written.
REQ-016 oMISSED  out  1  one-cycle pulse when a request is dropped.
REQ-017 oLINE_SUM  out  16  per-line byte checksum (see Configuration).

Function
REQ-018 SHALL use states IDLE, ISSUE, DRAIN, DONE; the FSM SHALL return to IDLE from DONE after one cycle.
- IDLE -> ISSUE on iLOAD_REQ.
- ISSUE -> DRAIN when the last read has been accepted.
- DRAIN -> DONE when the last pixel has been written.
REQ-019 SHALL compute the read address as FRAME_BASE + iLINE_ID*(LINE_PIXELS/2) + k, for k = 0..LINE_PIXELS/2-1, in 25-bit arithmetic with wrap-around.
REQ-020 SHALL count a read request as accepted only in a cycle where oRD_EN=1 and iWAIT_REQUEST=0.
REQ-021 SHALL hold oRD_ADDR stable while oRD_EN=1 and iWAIT_REQUEST=1.
REQ-022 SHALL assert oRD_EN only when (outstanding reads + buffered words) < MAX_PENDING.
REQ-023 SHALL buffer returned words in a MAX_PENDING-deep word FIFO, so that no iRD_DATAVALID beat is ever lost.
REQ-024 SHALL unpack each 16-bit word low byte first, then high byte, writing one pixel per cycle.
REQ-025 SHALL keep oWEN=0 whenever iWFULL=1; the unpacker SHALL stall and lose no data.
REQ-026 SHALL, for iLINE_ID >= NUM_LINES, issue no SDRAM reads and write LINE_PIXELS pixels of 8'h00, then pulse oDONE.
REQ-027 SHALL ignore iLOAD_REQ when not in IDLE and pulse oMISSED in the following cycle.
REQ-028 SHALL ignore iRD_DATAVALID in IDLE, so that stray returns after a reset are discarded.
REQ-029 SHALL drive oBUSY=1 in ISSUE, DRAIN and DONE.
REQ-030 SHALL have a latency of 1 cycle from iLOAD_REQ to the first oRD_EN.

Reset
REQ-031 SHALL, on iRST_N=0 (including mid-line), immediately reach IDLE and clear all counters and the word buffer, with all outputs 0.

Configuration
REQ-032 SHALL recognise macro SDRAM_VGA_LINE_READER_CHECKSUM_EN.
- Defined: oLINE_SUM = modulo-2^16 sum of the bytes written for the line, valid in the oDONE cycle, cleared on line start.
- Undefined: oLINE_SUM SHALL be tied to 16'h0 and no accumulator logic is present.

Structure
REQ-033 SHALL place the state enum, the default LINE_PIXELS/NUM_LINES and the 25-bit address width constant in a shared package, slm_vga_pkg.
REQ-034 SHALL implement the word buffer as sub-module line_word_fifo (16-bit, depth MAX_PENDING, show-ahead).

Verification
REQ-035 Nominal fetch: LINE_ID=3, no stalls -> first address 25'd1536; 512 reads; 1024 oWEN; bytes low/high ordered; single oDONE.
REQ-036 Read backpressure: iWAIT_REQUEST random at 50% -> oRD_ADDR stable under stall; 512 accepted reads, no duplicates.
REQ-037 FIFO backpressure: iWFULL high for 100 cycles mid-line -> oWEN=0 throughout; outstanding+buffered never exceeds 4; all 1024 bytes delivered in order.
REQ-038 Out-of-range: LINE_ID=800 -> zero oRD_EN; 1024 writes of 8'h00; oDONE.
REQ-039 Busy request: second iLOAD_REQ during ISSUE -> one oMISSED pulse; the current line completes unaltered.
REQ-040 Reset mid-line: iRST_N low after 100 reads, then DATAVALID beats arrive in IDLE -> all outputs 0; no oWEN; the next line fetches correctly.
